seg7_scan_reader: RTL and testbench

Reads back a multiplexed 7-segment display bus (segment lines plus one-hot digit strobes) and recovers the BCD digit shown on each position. It inverts the team's 0-9 segment encoding, filters glitches with a stability counter, and assembles complete multi-digit frames. Frames are handed downstream over a valid/ready handshake. It sits beside the display driver, for self-check and loopback test of the display path.

---
 rtl/seg7_pkg.sv | 28 ++
 rtl/seg7_pattern_to_bcd.sv | 29 ++
 rtl/seg7_scan_reader.sv | 154 +++++++++++++++
 tb/tb_seg7_scan_reader.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and segment table for the 7-segment scan reader.
// The SEG7_BLANK_EN build option makes all-off segments read back as a blank code.
package seg7_pkg;

    typedef logic [0:6] seg_t;

    localparam seg_t SEG_DIGIT [0:9] = '{
        7'b1111110,
        7'b0110000,
        7'b1101101,
        7'b1111001,
        7'b0110011,
        7'b1011011,
        7'b1011111,
        7'b1110000,
        7'b1111111,
        7'b1111011
    };

    localparam logic [3:0] CODE_ERR   = 4'hF;
    localparam logic [3:0] CODE_BLANK = 4'hA;

    typedef enum logic {
        COLLECT,
        PENDING
    } state_t;

endpackage

// File: rtl/seg7_pattern_to_bcd.sv
// seg7_pattern_to_bcd: exact-match inverse of the 0-9 segment table.
// SEG7_BLANK_EN defined: 0000000 reads as CODE_BLANK instead of an error.
module seg7_pattern_to_bcd
    import seg7_pkg::*;
(
    input  logic [0:6] pattern,
    output logic [3:0] code,
    output logic       err
);

    always_comb begin
        code = CODE_ERR;
        err  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (pattern == SEG_DIGIT[i]) begin
                code = 4'(i);
                err  = 1'b0;
            end
        end
`ifdef SEG7_BLANK_EN
        if (pattern == 7'b0000000) begin
            code = CODE_BLANK;
            err  = 1'b0;
        end
`else
`endif
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: recovers BCD frames from a multiplexed 7-segment bus.
// Optional SEG7_BLANK_EN (see seg7_pattern_to_bcd) accepts blank positions.
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int N_DIGITS      = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [0:6]              segs,
    input  logic [N_DIGITS-1:0]     digit_sel,
    output logic [4*N_DIGITS-1:0]   frame_digits,
    output logic [N_DIGITS-1:0]     frame_err,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic                    overrun
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] S_CNT = CW'(STABLE_CYCLES);

    seg_t                  segs_q;
    seg_t                  prev_segs;
    logic [N_DIGITS-1:0]   sel_q;
    logic [N_DIGITS-1:0]   prev_sel;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_next;
    logic [N_DIGITS-1:0]   seen;
    logic [4*N_DIGITS-1:0] dig_q;
    logic [N_DIGITS-1:0]   derr_q;

    logic       qual;
    logic       same;
    logic       capture;
    logic [3:0] code;
    logic       code_err;
    logic       seen_full;

    state_t state_q;
    state_t state_d;
    logic   load;
    logic   clr_seen;
    logic   set_ovr;
    logic   valid_d;
    logic   hs;

    seg7_pattern_to_bcd u_dec (
        .pattern (segs_q),
        .code    (code),
        .err     (code_err)
    );

    assign qual = (sel_q != '0) && ((sel_q & (sel_q - 1'b1)) == '0);
    assign same = (sel_q == prev_sel) && (segs_q == prev_segs);

    always_comb begin
        cnt_next = '0;
        if (qual) begin
            if (same && cnt != '0)
                cnt_next = (cnt == S_CNT) ? cnt : cnt + 1'b1;
            else
                cnt_next = CW'(1);
        end
    end

    // fire only on the edge the count first reaches the threshold
    assign capture   = qual && (cnt_next == S_CNT) && !(same && cnt == S_CNT);
    assign seen_full = &seen;
    assign hs        = frame_valid && frame_ready;

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        clr_seen = 1'b0;
        set_ovr  = 1'b0;
        valid_d  = frame_valid;
        case (state_q)
            COLLECT: begin
                if (seen_full) begin
                    load     = 1'b1;
                    clr_seen = 1'b1;
                    valid_d  = 1'b1;
                    state_d  = PENDING;
                end
            end
            PENDING: begin
                if (hs && seen_full) begin
                    load     = 1'b1;
                    clr_seen = 1'b1;
                end else if (hs) begin
                    valid_d  = 1'b0;
                    state_d  = COLLECT;
                end else if (seen_full) begin
                    set_ovr  = 1'b1;
                    clr_seen = 1'b1;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            segs_q    <= '0;
            sel_q     <= '0;
            prev_segs <= '0;
            prev_sel  <= '0;
            cnt       <= '0;
        end else begin
            segs_q    <= segs;
            sel_q     <= digit_sel;
            prev_segs <= segs_q;
            prev_sel  <= sel_q;
            cnt       <= cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dig_q  <= '0;
            derr_q <= '0;
            seen   <= '0;
        end else begin
            seen <= (clr_seen ? '0 : seen) | (capture ? sel_q : '0);
            for (int k = 0; k < N_DIGITS; k++) begin
                if (capture && sel_q[k]) begin
                    dig_q[4*k +: 4] <= code;
                    derr_q[k]       <= code_err;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= COLLECT;
            frame_digits <= '0;
            frame_err    <= '0;
            frame_valid  <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_valid <= valid_d;
            if (set_ovr)
                overrun <= 1'b1;
            if (load) begin
                frame_digits <= dig_q;
                frame_err    <= derr_q;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_reader.sv
// tb_seg7_scan_reader: directed scans with a frame scoreboard queue.
// Build with SEG7_BLANK_EN defined to exercise the blank-code path.
module tb_seg7_scan_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic [0:6]  segs;
    logic [3:0]  digit_sel;
    logic [15:0] frame_digits;
    logic [3:0]  frame_err;
    logic        frame_valid;
    logic        frame_ready;
    logic        overrun;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  e;
    } frame_t;

    frame_t sbq[$];

    logic [0:6] pat [10] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
        7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
    };

    seg7_scan_reader #(
        .N_DIGITS      (4),
        .STABLE_CYCLES (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .segs         (segs),
        .digit_sel    (digit_sel),
        .frame_digits (frame_digits),
        .frame_err    (frame_err),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic show(input int pos, input logic [0:6] p, input int n);
        digit_sel = 4'b0001 << pos;
        segs      = p;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        digit_sel = '0;
        segs      = '0;
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_frame(input string tag);
        frame_t f;
        int t = 0;
        while (frame_valid !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        f = (sbq.size() > 0) ? sbq.pop_front() : '1;
        check({tag, "_valid"}, 32'(frame_valid), 32'd1);
        check({tag, "_digits"}, 32'(frame_digits), 32'(f.d));
        check({tag, "_err"}, 32'(frame_err), 32'(f.e));
        if (frame_ready) begin
            @(negedge clk);
            check({tag, "_drop"}, 32'(frame_valid), 32'd0);
        end
    endtask

    initial begin
        rst         = 1'b1;
        frame_ready = 1'b1;
        digit_sel   = '0;
        segs        = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_digits", 32'(frame_digits), 32'h0);
        check("rst_err", 32'(frame_err), 32'h0);
        check("rst_valid", 32'(frame_valid), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);

        // basic scan 1,2,3,4
        sbq.push_back('{16'h4321, 4'b0000});
        for (int k = 0; k < 4; k++) show(k, pat[k+1], 3);
        idle(1);
        expect_frame("basic");

        // glitch: 2 cycles of '0' must not capture position 0
        sbq.push_back('{16'h7651, 4'b0000});
        show(1, pat[5], 3);
        show(2, pat[6], 3);
        show(3, pat[7], 3);
        show(0, pat[0], 2);
        show(0, pat[1], 3);
        idle(1);
        expect_frame("glitch");

        // non-digit pattern on position 2
        sbq.push_back('{16'h0F98, 4'b0100});
        show(0, pat[8], 3);
        show(1, pat[9], 3);
        show(2, 7'b1010101, 3);
        show(3, pat[0], 3);
        idle(1);
        expect_frame("badpat");

        // backpressure: second frame dropped, first held
        frame_ready = 1'b0;
        sbq.push_back('{16'h5432, 4'b0000});
        for (int k = 0; k < 4; k++) show(k, pat[k+2], 3);
        for (int k = 0; k < 4; k++) show(k, pat[k+6], 3);
        idle(5);
        check("bp_valid", 32'(frame_valid), 32'd1);
        check("bp_held", 32'(frame_digits), 32'h5432);
        check("bp_overrun", 32'(overrun), 32'd1);
        frame_ready = 1'b1;
        expect_frame("bp");
        check("bp_overrun_sticky", 32'(overrun), 32'd1);

        // multi-hot select must not capture
        digit_sel = 4'b0011;
        segs      = pat[1];
        repeat (10) @(negedge clk);
        show(2, pat[2], 3);
        show(3, pat[3], 3);
        idle(20);
        check("multihot_noframe", 32'(frame_valid), 32'd0);

        // reset mid-scan discards partial data
        show(1, pat[4], 2);
        rst = 1'b1;
        idle(2);
        check("mrst_digits", 32'(frame_digits), 32'h0);
        check("mrst_err", 32'(frame_err), 32'h0);
        check("mrst_valid", 32'(frame_valid), 32'h0);
        check("mrst_overrun", 32'(overrun), 32'h0);
        rst = 1'b0;
        show(0, pat[5], 3);
        show(1, pat[5], 3);
        idle(20);
        check("mrst_noframe", 32'(frame_valid), 32'd0);
        sbq.push_back('{16'h6789, 4'b0000});
        for (int k = 0; k < 4; k++) show(k, pat[9-k], 3);
        idle(1);
        expect_frame("after_rst");

        // all-off segments on position 3
`ifdef SEG7_BLANK_EN
        sbq.push_back('{16'hA321, 4'b0000});
`else
        sbq.push_back('{16'hF321, 4'b1000});
`endif
        show(0, pat[1], 3);
        show(1, pat[2], 3);
        show(2, pat[3], 3);
        show(3, 7'b0000000, 3);
        idle(1);
        expect_frame("blank");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
